// File: rtl/fifo_pkg.sv
// Shared defaults, flag bundle and address-wrap helper for the FIFO controller.
package fifo_pkg;

    localparam int unsigned ADDRSIZE_DEF = 8;
    localparam int unsigned DEPTH_DEF    = 90;
    localparam int unsigned AF_LEVEL_DEF = DEPTH_DEF - 4;
    localparam int unsigned AE_LEVEL_DEF = 4;

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{
        wfull:        1'b0,
        rempty:       1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Next address with modulo-depth wrap (depth need not be a power of two).
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH incrementing address register with enable.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned AW    = ADDRSIZE_DEF - 1,
    parameter int unsigned DEPTH = DEPTH_DEF
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] addr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (en) begin
            addr <= AW'(next_addr(32'(addr), DEPTH));
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller for an external memory with one-cycle registered read.
// Optional sticky overflow/underflow outputs are enabled with `define FIFO_CTRL_ERR_EN.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = AE_LEVEL_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    output logic                wr_en,
    output logic                wfull,
    output logic [ADDRSIZE-2:0] wr_addr,
    output logic                rd_en,
    output logic [ADDRSIZE-2:0] rd_addr,
    output logic                rempty,
    output logic                rd_valid,
    output logic [ADDRSIZE-1:0] count,
    output logic                almost_full,
    output logic                almost_empty
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic                overflow,
    output logic                underflow
`endif
);

    localparam int unsigned AW = ADDRSIZE - 1;
    localparam int unsigned CW = ADDRSIZE;

    fifo_flags_t   flags_q;
    fifo_flags_t   flags_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Strobes use the current registered flags; reset blocks any transfer.
    always_comb begin
        wr_en = push & ~flags_q.wfull  & ~rst;
        rd_en = pop  & ~flags_q.rempty & ~rst;
    end

    // Flags are computed from the next count so they land together with it.
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        flags_d.wfull        = (count_d == CW'(DEPTH));
        flags_d.rempty       = (count_d == '0);
        flags_d.almost_full  = (count_d >= CW'(AF_LEVEL));
        flags_d.almost_empty = (count_d <= CW'(AE_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            flags_q  <= FLAGS_RST;
            rd_valid <= 1'b0;
        end else begin
            count_q  <= count_d;
            flags_q  <= flags_d;
            rd_valid <= rd_en;
        end
    end

    assign count        = count_q;
    assign wfull        = flags_q.wfull;
    assign rempty       = flags_q.rempty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;

    fifo_ptr #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .en   (wr_en),
        .addr (wr_addr)
    );

    fifo_ptr #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_en),
        .addr (rd_addr)
    );

`ifdef FIFO_CTRL_ERR_EN
    // Sticky error flags: only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && flags_q.wfull) begin
                overflow <= 1'b1;
            end
            if (pop && flags_q.rempty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 8, memory address bits; the memory address ports are ADDRSIZE-1 bits wide.
REQ-002 SHALL have parameter DEPTH, default 90, number of memory words; legal range 2..2^(ADDRSIZE-1).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 4, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock for all logic; one clock only.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port push  input  1  write request from producer.
REQ-008 SHALL have port pop  input  1  read request from consumer.
REQ-009 SHALL have port wr_en  output  1  memory write strobe, equal to accepted push.
REQ-010 SHALL have port wfull  output  1  memory/producer full flag.
REQ-011 SHALL have port wr_addr  output  ADDRSIZE-1  memory write address.
REQ-012 SHALL have port rd_en  output  1  memory read strobe, equal to accepted pop.
REQ-013 SHALL have port rd_addr  output  ADDRSIZE-1  memory read address.
REQ-014 SHALL have port rempty  output  1  empty flag.
REQ-015 SHALL have port rd_valid  output  1  memory rd_data valid this cycle.
REQ-016 SHALL have port count  output  ADDRSIZE  current occupancy, 0..DEPTH.
REQ-017 SHALL have ports almost_full, almost_empty  output  1 each  threshold flags.

Function
REQ-018 SHALL accept push only when wfull is low; push while wfull is high is dropped, even with a simultaneous accepted pop.
REQ-019 SHALL accept pop only when rempty is low; pop while empty is dropped, even with a simultaneous push.
REQ-020 SHALL drive wr_en = push & !wfull and rd_en = pop & !rempty combinationally from the current-cycle flags.
REQ-021 SHALL advance wr_addr by 1 on each accepted push; DEPTH-1 wraps to 0, not to 2^(ADDRSIZE-1).
REQ-022 SHALL advance rd_addr by 1 on each accepted pop, with the same wrap rule as wr_addr.
REQ-023 SHALL update count as +1 on push only, -1 on pop only, and unchanged on a simultaneous accepted push and pop.
REQ-024 SHALL register the flags: wfull = (count==DEPTH), rempty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL), all valid the cycle after the count update.
REQ-025 SHALL assert rd_valid exactly one cycle after each accepted pop, matching the one-cycle registered memory read.
REQ-026 SHALL read the oldest word when simultaneous push and pop occur at count==1; the written word is not returned in that cycle.

Reset
REQ-027 SHALL, while rst is high at a clk edge, set wr_addr=0, rd_addr=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, rd_valid=0.
REQ-028 SHALL force wr_en and rd_en low while rst is high, so push/pop during reset are discarded.
REQ-029 SHALL discard mid-operation contents on reset; a pop issued in the cycle before reset produces no rd_valid after reset.

Configuration
REQ-030 SHALL, when FIFO_CTRL_ERR_EN is defined, add sticky outputs overflow and underflow (1 bit each); these set on a dropped push or pop respectively and clear only on rst.
REQ-031 SHALL, without FIFO_CTRL_ERR_EN, omit the overflow and underflow ports and logic entirely, with all other behaviour unchanged.

Structure
REQ-032 SHALL take the default ADDRSIZE, DEPTH, AF_LEVEL and AE_LEVEL constants from a shared package fifo_pkg, along with a helper for the next address with wrap.
REQ-033 SHALL instantiate sub-module fifo_ptr, a modulo-DEPTH incrementing address register with enable, twice: once for writes and once for reads.

Verification
REQ-034 SHALL verify: rst, then 90 pushes with no pop -> wfull=1, count=90, wr_addr=0; the 91st push gives wr_en=0.
REQ-035 SHALL verify: after the fill, 90 pops -> rd_addr sequence 0..89 then 0, rempty=1, rd_valid once per pop, one cycle late.
REQ-036 SHALL verify: from empty, push and pop in the same cycle -> rd_en=0, count=1; at count=1 the same -> count stays 1 and rd_addr advances.
REQ-037 SHALL verify threshold transitions: count 85 -> 86 raises almost_full; count 5 -> 4 raises almost_empty.
REQ-038 SHALL verify: rst asserted at count=37 during a pop -> next cycle count=0, both addresses 0, rd_valid=0.
REQ-039 SHALL verify, with FIFO_CTRL_ERR_EN: a pop at empty sets underflow=1, which holds until rst; a push at full sets overflow=1.
